// File: rtl/am_sample_shaper.sv
// AM sample shaper: signed audio -> depth/offset scaling -> saturated 8-bit duty -> FWFT FIFO.
// Optional saturation statistics (sat_count, sat_flag) when AM_SHAPER_STATS_EN is defined.
`timescale 1ns/1ps
module am_sample_shaper #(
  parameter int IN_WIDTH   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [IN_WIDTH-1:0]           in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    mod_index,
  input  logic [7:0]                    offset,
  output logic [7:0]                    sample,
  output logic                          empty,
  input  logic                          read,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef AM_SHAPER_STATS_EN
  ,
  output logic [15:0]                   sat_count,
  output logic                          sat_flag
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = IN_WIDTH + 9;
  localparam int VW = IN_WIDTH + 10;

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both 1;
  // in_valid/in_sample may change freely otherwise, and in_ready never depends on in_valid.

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;
  logic [VW-1:0]        w_v;
  logic [7:0]           w_duty;
  logic                 w_sat;
  logic                 w_accept;
  logic                 w_wr;
  logic                 w_rd;
  logic [LW:0]          w_occ;

  logic signed [PW-1:0] r_s1_p;
  logic [7:0]           r_s1_off;
  logic                 r_s1_valid;
  logic [7:0]           r_s2_duty;
  logic                 r_s2_sat;
  logic                 r_s2_valid;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [LW-1:0]        r_level;
  logic [7:0]           r_last;

  assign w_a    = {{9{in_sample[IN_WIDTH-1]}}, in_sample};
  assign w_b    = {{(IN_WIDTH+1){1'b0}}, mod_index};
  assign w_prod = w_a * w_b;

  // Floor-scaled product plus offset, one guard bit wide so the sign is always exact.
  assign w_shift = r_s1_p >>> 8;
  assign w_v     = {w_shift[PW-1], w_shift} + {{(VW-8){1'b0}}, r_s1_off};

  always_comb begin
    w_duty = w_v[7:0];
    w_sat  = 1'b0;
    if (w_v[VW-1]) begin
      w_duty = 8'd0;
      w_sat  = 1'b1;
    end else if (|w_v[VW-2:8]) begin
      w_duty = 8'd255;
      w_sat  = 1'b1;
    end
  end

  // Occupancy counts in-flight stage entries so a write can never land on a full FIFO.
  assign w_occ    = {1'b0, r_level} + {{LW{1'b0}}, r_s1_valid} + {{LW{1'b0}}, r_s2_valid};
  assign in_ready = enable & ~rst & (w_occ < (LW+1)'(FIFO_DEPTH));
  assign w_accept = in_valid & in_ready;
  assign w_wr     = r_s2_valid;
  assign w_rd     = read & (r_level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_p     <= '0;
      r_s1_off   <= '0;
      r_s1_valid <= 1'b0;
      r_s2_duty  <= '0;
      r_s2_sat   <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_p   <= w_prod;
        r_s1_off <= offset;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_duty <= w_duty;
        r_s2_sat  <= w_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) begin
      r_mem[r_wr_ptr] <= r_s2_duty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Remember the current head so sample holds its last value once the FIFO drains.
      if (r_level != '0) r_last <= r_mem[r_rd_ptr];
    end
  end

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(FIFO_DEPTH));
  assign level  = r_level;
  assign sample = empty ? r_last : r_mem[r_rd_ptr];

`ifdef AM_SHAPER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
      sat_flag  <= 1'b0;
    end else if (flush) begin
      sat_count <= '0;
      sat_flag  <= 1'b0;
    end else if (w_wr && r_s2_sat) begin
      if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_am_sample_shaper.sv
// Randomized bench for am_sample_shaper against a queue-based reference of the shaping rules.
`timescale 1ns/1ps
module tb_am_sample_shaper;
  localparam int IW = 8;
  localparam int D  = 16;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          flush;
  logic [IW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    mod_index;
  logic [7:0]    offset;
  logic [7:0]    sample;
  logic          empty;
  logic          read;
  logic          full;
  logic [4:0]    level;
`ifdef AM_SHAPER_STATS_EN
  logic [15:0]   sat_count;
  logic          sat_flag;
`endif

  am_sample_shaper #(.IN_WIDTH(IW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .mod_index(mod_index), .offset(offset),
    .sample(sample), .empty(empty), .read(read), .full(full), .level(level)
`ifdef AM_SHAPER_STATS_EN
    , .sat_count(sat_count), .sat_flag(sat_flag)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    bit         sat;
    int         due;
  } pend_t;

  // scoreboard state
  logic [7:0] exp_q[$];
  pend_t      pend_q[$];
  logic [7:0] last_head;
  int         sat_cnt_m;
  bit         sat_flag_m;
  int         cyc;
  int         n_vec;
  int         n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Duty = clamp(floor(s*m/256) + o, 0, 255)
  function automatic void ref_duty(input int s, input int m, input int o,
                                   output logic [7:0] d, output bit sat);
    int p;
    int fl;
    int v;
    p  = s * m;
    fl = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    v  = fl + o;
    sat = (v < 0) || (v > 255);
    if (v < 0) d = 8'd0;
    else if (v > 255) d = 8'd255;
    else d = v[7:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    last_head  = 8'd0;
    sat_cnt_m  = 0;
    sat_flag_m = 0;
  endtask

  function automatic bit exp_ready();
    return enable && ((exp_q.size() + pend_q.size()) < D);
  endfunction

  task automatic check_outputs();
    check_val("empty", empty, exp_q.size() == 0);
    check_val("level", level, exp_q.size());
    check_val("full", full, exp_q.size() == D);
    check_val("in_ready", in_ready, exp_ready());
    check_val("sample", sample, (exp_q.size() != 0) ? exp_q[0] : last_head);
`ifdef AM_SHAPER_STATS_EN
    check_val("sat_count", sat_count, sat_cnt_m);
    check_val("sat_flag", sat_flag, sat_flag_m);
`endif
  endtask

  // driver: one clock with checks at the falling edge and model update at the rising edge
  task automatic cycle();
    bit         acc;
    bit         pop;
    bit         fl;
    logic [7:0] d;
    bit         sat;
    int         s;
    @(negedge clk);
    check_outputs();
    fl  = flush;
    acc = in_valid && exp_ready();
    pop = read && (exp_q.size() != 0);
    s   = (in_sample >= 8'd128) ? int'(in_sample) - 256 : int'(in_sample);
    ref_duty(s, int'(mod_index), int'(offset), d, sat);
    @(posedge clk);
    cyc++;
    if (fl) begin
      model_clear();
    end else begin
      if (pop) last_head = exp_q.pop_front();
      while (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        exp_q.push_back(pend_q[0].v);
        if (pend_q[0].sat) begin
          if (sat_cnt_m < 65535) sat_cnt_m++;
          sat_flag_m = 1;
        end
        void'(pend_q.pop_front());
      end
      if (acc) pend_q.push_back('{d, sat, cyc + 2});
    end
    #1;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_val("arst_empty", empty, 1);
    check_val("arst_level", level, 0);
    check_val("arst_full", full, 0);
    check_val("arst_sample", sample, 0);
    check_val("arst_ready", in_ready, 0);
    model_clear();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    model_clear();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; in_sample = '0; in_valid = 1'b0;
    mod_index = 8'd0; offset = 8'd0; read = 1'b0;
    #1;
    check_val("rst_empty", empty, 1);
    check_val("rst_level", level, 0);
    check_val("rst_full", full, 0);
    check_val("rst_sample", sample, 0);
    check_val("rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cycle();
    enable = 1'b1;
    repeat (2) cycle();

    // nominal shaping, then a negative sample
    mod_index = 8'd128; offset = 8'd128;
    in_sample = 8'd100; in_valid = 1'b1;
    cycle();
    in_sample = 8'd156;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    check_val("t2_first", sample, 178);
    read = 1'b1;
    cycle();
    read = 1'b0;
    check_val("t2_second", sample, 78);
    read = 1'b1;
    cycle();
    read = 1'b0;
    cycle();
    check_val("t2_hold", sample, 78);

    // saturation at both rails
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    offset = 8'd250; mod_index = 8'd255; in_sample = 8'd127; in_valid = 1'b1;
    cycle();
    offset = 8'd5; in_sample = 8'h80;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    check_val("t3_hi", sample, 255);
`ifdef AM_SHAPER_STATS_EN
    check_val("t3_sat_count", sat_count, 2);
    check_val("t3_sat_flag", sat_flag, 1);
`endif
    read = 1'b1;
    cycle();
    check_val("t3_lo", sample, 0);
    repeat (2) cycle();
    read = 1'b0;

    // fill without reading, then drain in order
    mod_index = 8'd200; offset = 8'd128; in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_sample = IW'($urandom_range(0, 255));
      cycle();
    end
    check_val("t4_full", full, 1);
    check_val("t4_level", level, D);
    in_valid = 1'b0; read = 1'b1;
    repeat (18) cycle();
    read = 1'b0;

    // full FIFO with continuous read and continuous input
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sample = IW'($urandom_range(0, 255));
      cycle();
    end
    read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_sample = IW'($urandom_range(0, 255));
      offset = 8'($urandom_range(0, 255));
      cycle();
    end
    in_valid = 1'b0;
    repeat (20) cycle();
    read = 1'b0;

    // async reset mid-stream, then flush with read and input active
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sample = IW'($urandom_range(0, 255));
      cycle();
    end
    async_reset();
    repeat (8) begin
      in_sample = IW'($urandom_range(0, 255));
      cycle();
    end
    flush = 1'b1; read = 1'b1;
    cycle();
    flush = 1'b0; read = 1'b0; in_valid = 1'b0;
    check_val("t6_flush_level", level, 0);
    repeat (4) cycle();
    check_val("t6_flush_empty", empty, 1);

    // random mixed traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      read      = ($urandom_range(0, 1) == 1);
      enable    = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_sample = IW'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) mod_index = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) offset = 8'($urandom_range(0, 255));
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; read = 1'b1; enable = 1'b1;
    repeat (24) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
